// File: rtl/arm_mem_pkg.sv
// Shared definitions for the memory port arbiter.
//   arb_state_t : arbiter FSM state encoding (IDLE, BUSY, RESP)
//   OWNER_IF/D  : owner encodings reported on the arbiter's owner port
//   ERR_RDATA   : read data returned to the owner when a transaction times out
//   sat_inc     : saturating increment used by the starvation counter
package arm_mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } arb_state_t;

   localparam logic OWNER_IF = 1'b0;
   localparam logic OWNER_D  = 1'b1;

   localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

   function automatic logic [3:0] sat_inc(input logic [3:0] val, input logic [3:0] lim);
      return (val >= lim) ? lim : val + 4'd1;
   endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Busy-cycle watchdog for the memory port arbiter.
// Ports:
//   clk, rst : clock and synchronous active-low reset
//   clear    : zero the count (asserted on the grant that enters BUSY)
//   run      : count this cycle (high while the arbiter is in BUSY)
//   expired  : high during the LIMIT-th consecutive run cycle
module mem_arb_timer #(
   parameter int unsigned LIMIT = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic run,
   output logic expired
);

   localparam int unsigned W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

   logic [W-1:0] cnt;

   assign expired = run && (cnt == W'(LIMIT - 1));

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (run && !expired) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between instruction fetch and data load/store.
// One transaction at a time: IDLE (arbitrate) -> BUSY (wait mem_ack) -> RESP (done pulse).
// Data wins arbitration unless fetch has lost STARVE_LIMIT times in a row.
// Optional feature MEM_ARB_TIMEOUT_EN: abort BUSY after TIMEOUT_CYCLES without mem_ack,
// returning ERR_RDATA and pulsing err alongside the owner's done.
// Ports:
//   clk, rst                          : clock, synchronous active-low reset
//   if_req/if_addr/if_rdata/if_done   : fetch requester
//   d_req/d_we/d_addr/d_wdata/d_rdata/d_done : data requester
//   mem_req/mem_we/mem_addr/mem_wdata/mem_ack/mem_rdata : memory port
//   owner : current/last grant (0 fetch, 1 data); busy : in BUSY or RESP; err : timeout pulse
module mem_port_arbiter
   import arm_mem_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT   = 4,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_done,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic [31:0] d_rdata,
   output logic        d_done,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        owner,
   output logic        busy,
   output logic        err
);

   if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("mem_port_arbiter: STARVE_LIMIT must be 1..15 and TIMEOUT_CYCLES >= 1");
   end

   localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

   arb_state_t state;
   logic [3:0] starve_cnt;
   logic       grant_d;
   logic       grant_if;
   logic       tmo_expired;

   always_comb begin
      grant_d  = 1'b0;
      grant_if = 1'b0;
      if (state == IDLE) begin
         grant_d  = d_req && !(if_req && (starve_cnt == STARVE_MAX));
         grant_if = if_req && !grant_d;
      end
   end

`ifdef MEM_ARB_TIMEOUT_EN
   mem_arb_timer #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (grant_d || grant_if),
      .run     (state == BUSY),
      .expired (tmo_expired)
   );
`else
   assign tmo_expired = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         starve_cnt <= 4'd0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= 32'd0;
         mem_wdata  <= 32'd0;
         if_rdata   <= 32'd0;
         d_rdata    <= 32'd0;
         if_done    <= 1'b0;
         d_done     <= 1'b0;
         owner      <= OWNER_IF;
         busy       <= 1'b0;
         err        <= 1'b0;
      end else begin
         if_done <= 1'b0;
         d_done  <= 1'b0;
         err     <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_d) begin
                  mem_addr  <= d_addr;
                  mem_we    <= d_we;
                  mem_wdata <= d_wdata;
                  owner     <= OWNER_D;
                  mem_req   <= 1'b1;
                  busy      <= 1'b1;
                  state     <= BUSY;
                  // Only a contested win by data counts against fetch.
                  if (if_req) begin
                     starve_cnt <= sat_inc(starve_cnt, STARVE_MAX);
                  end
               end else if (grant_if) begin
                  mem_addr   <= if_addr;
                  mem_we     <= 1'b0;
                  mem_wdata  <= 32'd0;
                  owner      <= OWNER_IF;
                  mem_req    <= 1'b1;
                  busy       <= 1'b1;
                  state      <= BUSY;
                  starve_cnt <= 4'd0;
               end
            end
            BUSY: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  if (!mem_we) begin
                     if (owner == OWNER_D) d_rdata  <= mem_rdata;
                     else                  if_rdata <= mem_rdata;
                  end
                  if (owner == OWNER_D) d_done  <= 1'b1;
                  else                  if_done <= 1'b1;
                  state <= RESP;
               end else if (tmo_expired) begin
                  mem_req <= 1'b0;
                  err     <= 1'b1;
                  if (owner == OWNER_D) begin
                     d_rdata <= ERR_RDATA;
                     d_done  <= 1'b1;
                  end else begin
                     if_rdata <= ERR_RDATA;
                     if_done  <= 1'b1;
                  end
                  state <= RESP;
               end
            end
            RESP: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state   <= IDLE;
               mem_req <= 1'b0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
// Runs the timeout scenario when MEM_ARB_TIMEOUT_EN is defined, otherwise checks that
// BUSY waits indefinitely with err held low.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_rdata;
   logic        if_done;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_done;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        owner;
   logic        busy;
   logic        err;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .STARVE_LIMIT   (4),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_rdata  (if_rdata),
      .if_done   (if_done),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_rdata   (d_rdata),
      .d_done    (d_done),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .owner     (owner),
      .busy      (busy),
      .err       (err)
   );

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   logic expected_owner [6];

   initial begin
      expected_owner = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      rst = 1'b0; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
      d_addr = '0; d_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
      tick(); tick();
      chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_owner", {31'd0, owner}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      rst = 1'b1;

      // Single fetch, ack two cycles after mem_req rises.
      if_req = 1'b1; if_addr = 32'h100;
      tick();
      chk("if_mem_req", {31'd0, mem_req}, 32'd1);
      chk("if_mem_addr", mem_addr, 32'h100);
      chk("if_mem_we", {31'd0, mem_we}, 32'd0);
      chk("if_owner", {31'd0, owner}, 32'd0);
      tick();
      chk("if_wait_req", {31'd0, mem_req}, 32'd1);
      chk("if_wait_done", {31'd0, if_done}, 32'd0);
      mem_ack = 1'b1; mem_rdata = 32'hE3A0_00BB;
      tick();
      mem_ack = 1'b0; if_req = 1'b0;
      chk("if_done", {31'd0, if_done}, 32'd1);
      chk("if_rdata", if_rdata, 32'hE3A0_00BB);
      chk("if_req_drop", {31'd0, mem_req}, 32'd0);
      chk("if_busy_resp", {31'd0, busy}, 32'd1);
      tick();
      chk("if_done_once", {31'd0, if_done}, 32'd0);
      chk("if_idle_busy", {31'd0, busy}, 32'd0);

      // Zero-wait load to give d_rdata a known value.
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000;
      tick();
      chk("ld_owner", {31'd0, owner}, 32'd1);
      chk("ld_mem_we", {31'd0, mem_we}, 32'd0);
      mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
      tick();
      mem_ack = 1'b0; d_req = 1'b0;
      chk("ld_done", {31'd0, d_done}, 32'd1);
      chk("ld_rdata", d_rdata, 32'hCAFE_F00D);
      tick();

      // Zero-wait store; inputs change after grant and must not leak through.
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'h1234_5678;
      tick();
      d_addr = 32'hFFFF_0000; d_wdata = 32'h0BAD_0BAD; d_we = 1'b0;
      chk("st_mem_we", {31'd0, mem_we}, 32'd1);
      chk("st_mem_addr", mem_addr, 32'h2000);
      chk("st_mem_wdata", mem_wdata, 32'h1234_5678);
      mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
      tick();
      mem_ack = 1'b0; d_req = 1'b0;
      chk("st_done", {31'd0, d_done}, 32'd1);
      chk("st_rdata_kept", d_rdata, 32'hCAFE_F00D);
      chk("st_if_done", {31'd0, if_done}, 32'd0);
      tick();
      chk("st_done_once", {31'd0, d_done}, 32'd0);

      // Stray ack in IDLE.
      mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
      tick();
      tick();
      mem_ack = 1'b0;
      chk("stray_busy", {31'd0, busy}, 32'd0);
      chk("stray_req", {31'd0, mem_req}, 32'd0);
      chk("stray_dones", {30'd0, if_done, d_done}, 32'd0);
      chk("stray_rdata", d_rdata, 32'hCAFE_F00D);

      // Both requesters held: D D D D IF D.
      if_req = 1'b1; if_addr = 32'h400;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk($sformatf("prio_owner%0d", i), {31'd0, owner}, {31'd0, expected_owner[i]});
         chk($sformatf("prio_addr%0d", i), mem_addr,
             expected_owner[i] ? 32'h500 : 32'h400);
         mem_ack = 1'b1; mem_rdata = 32'h1000 + 32'(i);
         tick();
         mem_ack = 1'b0;
         chk($sformatf("prio_done%0d", i), {30'd0, if_done, d_done},
             expected_owner[i] ? 32'd1 : 32'd2);
         tick();
      end
      if_req = 1'b0; d_req = 1'b0;
      tick();

      // Reset while BUSY, then a late ack.
      if_req = 1'b1; if_addr = 32'h900;
      tick();
      chk("mid_busy", {31'd0, mem_req}, 32'd1);
      rst = 1'b0; if_req = 1'b0;
      tick(); tick();
      rst = 1'b1;
      chk("mid_rst_req", {31'd0, mem_req}, 32'd0);
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_done", {30'd0, if_done, d_done}, 32'd0);
      chk("mid_rst_addr", mem_addr, 32'd0);
      chk("mid_rst_rdata", d_rdata, 32'd0);
      mem_ack = 1'b1; mem_rdata = 32'h4444_4444;
      tick();
      mem_ack = 1'b0;
      tick();
      chk("late_ack_done", {30'd0, if_done, d_done}, 32'd0);
      chk("late_ack_rdata", if_rdata, 32'd0);

      // No ack: timeout abort, or indefinite wait without the feature.
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600;
      tick();
`ifdef MEM_ARB_TIMEOUT_EN
      for (int i = 1; i < 8; i++) begin
         tick();
         chk($sformatf("tmo_wait%0d", i), {30'd0, mem_req, err}, 32'd2);
      end
      tick();
      d_req = 1'b0;
      chk("tmo_req", {31'd0, mem_req}, 32'd0);
      chk("tmo_done", {31'd0, d_done}, 32'd1);
      chk("tmo_err", {31'd0, err}, 32'd1);
      chk("tmo_rdata", d_rdata, 32'hDEAD_BEEF);
      tick();
      chk("tmo_err_once", {30'd0, err, d_done}, 32'd0);
`else
      for (int i = 1; i < 20; i++) begin
         tick();
         chk($sformatf("wait%0d", i), {30'd0, mem_req, err}, 32'd2);
      end
      mem_ack = 1'b1; mem_rdata = 32'h6666_6666;
      tick();
      mem_ack = 1'b0; d_req = 1'b0;
      chk("wait_done", {31'd0, d_done}, 32'd1);
      chk("wait_err", {31'd0, err}, 32'd0);
      chk("wait_rdata", d_rdata, 32'h6666_6666);
      tick();
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single external memory port between the core's instruction-fetch requester and its data load/store requester.
- Sits between arm_core's inst_addr/mem_addr/mem_data_in/mem_write_en paths and the memory.
- Sequences one transaction at a time with a req/ack handshake.
- Data has priority over fetch; a starvation guard bounds how long fetch can be blocked.

Parameters:
- STARVE_LIMIT, 4: consecutive lost arbitrations after which fetch wins once (range 1..15).
- TIMEOUT_CYCLES, 64: cycles in BUSY without mem_ack before abort; used only with the optional feature.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- if_req  in  1  fetch request; held until if_done
- if_addr  in  32  fetch address; stable while if_req
- if_rdata  out  32  fetched instruction
- if_done  out  1  one-cycle completion pulse for fetch
- d_req  in  1  data request; held until d_done
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_rdata  out  32  load data
- d_done  out  1  one-cycle completion pulse for data
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_ack  in  1  memory completion; mem_rdata valid in the same cycle
- mem_rdata  in  32  memory read data
- owner  out  1  current/last grant: 0 = fetch, 1 = data
- busy  out  1  high in BUSY or RESP
- err  out  1  timeout pulse; tied 0 without the feature

Behaviour:
- Reset: reset is synchronous, active-low, on clk. When rst is 0 at a clk edge:
  - State goes to IDLE.
  - mem_req, mem_we, if_done, d_done, err, busy and owner all go to 0.
  - mem_addr, mem_wdata, if_rdata and d_rdata go to 0.
  - Starvation counter goes to 0.
  - Reset mid-transaction abandons it; no done pulse is produced, and a late mem_ack is ignored.
- All outputs are registered.
- States: IDLE -> BUSY -> RESP -> IDLE.
- IDLE:
  - Samples if_req and d_req.
  - Grant to data if d_req && !(if_req && starve_cnt == STARVE_LIMIT); else grant to fetch if if_req; else stay in IDLE.
  - On grant: latch addr, we (fetch forces we = 0) and wdata into the mem_* registers; set mem_req = 1; set owner; go to BUSY.
- BUSY: mem_req held at 1 and mem_* outputs stable until mem_ack. On mem_ack:
  - mem_req goes to 0.
  - For a load or fetch, mem_rdata is captured into d_rdata or if_rdata.
  - For a store, d_rdata keeps its previous value.
  - Go to RESP.
- RESP: the owner's done output is 1 for exactly this cycle. Next state is IDLE. Requests are not sampled in RESP; the requester drops or changes req on this edge.
- Latency: request sampled in IDLE at cycle 0; mem_req high in cycle 1; with a zero-wait ack in cycle 1, done is high in cycle 2.
  - Minimum of 3 cycles per transaction.
  - Back-to-back throughput is 1 transaction per 3 cycles.
- Starvation counter (saturating at STARVE_LIMIT):
  - Increments when both requests are present in IDLE and data wins.
  - Clears whenever fetch is granted.
  - Unchanged otherwise.
- Simultaneous requests with starve_cnt < STARVE_LIMIT: data wins. With starve_cnt == STARVE_LIMIT: fetch wins and the counter clears.
- mem_ack in IDLE or RESP is ignored.
- d_we/d_addr/d_wdata changing while d_req is held: no effect after the grant, because the values are latched.

Optional Feature:
- Macro MEM_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in BUSY. If TIMEOUT_CYCLES elapse without mem_ack, mem_req drops and the FSM goes to RESP.
  - In RESP: the owner's done pulses, err pulses in the same cycle, and the owner's rdata = 32'hDEAD_BEEF.
  - The counter clears on entry to BUSY.
- Not defined: BUSY waits indefinitely for mem_ack; the err port is constant 0; no timeout counter exists.

Decomposition:
- Package arm_mem_pkg holds:
  - the state encoding (IDLE, BUSY, RESP)
  - owner encodings (OWNER_IF = 0, OWNER_D = 1)
  - the ERR_RDATA constant 32'hDEAD_BEEF
- Sub-module mem_arb_timer (load/clear/expire counter) is natural. It is instantiated only under MEM_ARB_TIMEOUT_EN.

Test Plan:
- Reset: hold rst = 0 for 2 cycles during BUSY -> mem_req = 0, state IDLE, no done pulse, outputs 0.
- Single fetch: if_req = 1, if_addr = 0x100; memory acks 2 cycles after mem_req with mem_rdata = 0xE3A000BB -> mem_addr = 0x100, mem_we = 0, if_rdata = 0xE3A000BB, if_done pulses once in the cycle after ack.
- Store: d_req = 1, d_we = 1, d_addr = 0x2000, d_wdata = 0x12345678; zero-wait ack -> mem_we = 1 with those values; d_done in cycle 2; d_rdata unchanged.
- Priority and starvation: both requests held continuously, STARVE_LIMIT = 4 -> grant order D, D, D, D, IF, D, ...; owner sequence matches.
- Stray ack: mem_ack pulses in IDLE -> no done pulse, no state change.
- Timeout (MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 8): never ack -> after 8 BUSY cycles mem_req = 0, d_done and err pulse together, d_rdata = 0xDEADBEEF.
